// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 access codes, data-memory FSM
// encoding and load-extension helpers.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        return sgn ? {{16{h[15]}}, h} : {16'h0, h};
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage load/store port between the pipeline (master) and data memory (slave).
interface data_memory_if;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    modport master (
        output memread, memwrite, funct3, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  memread, memwrite, funct3, addr, wdata,
        output rdata, stall, err
    );
endinterface

// File: rtl/dmem_align.sv
// Combinational lane logic: request checking, load extraction and store merge
// of store data into the currently addressed word.
module dmem_align
    import rv32i_pkg::*;
(
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] rdata,
    output logic [31:0] wword,
    output logic        err
);

    logic        req;
    logic        f3_illegal;
    logic        misaligned;
    logic [3:0]  be;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] wdata_rep;

    assign req = memread | memwrite;

    // A store wins when both strobes are high, so legality follows the store table.
    always_comb begin
        f3_illegal = 1'b0;
        if (memwrite)
            f3_illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            f3_illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    assign misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0])
                      | ((funct3 == F3_W) & (addr_lo != 2'b00));
    assign err = req & (f3_illegal | misaligned);

    always_comb begin
        sel_byte = rword[7:0];
        case (addr_lo)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
    end

    assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata = 32'h0;
        if (memread & ~memwrite & ~err) begin
            case (funct3)
                F3_B:    rdata = ext_byte(sel_byte, 1'b1);
                F3_BU:   rdata = ext_byte(sel_byte, 1'b0);
                F3_H:    rdata = ext_half(sel_half, 1'b1);
                F3_HU:   rdata = ext_half(sel_half, 1'b0);
                F3_W:    rdata = rword;
                default: rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            F3_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wword[gi*8 +: 8] = be[gi] ? wdata_rep[gi*8 +: 8] : rword[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: combinational-read word array with lane-merged writes
// and an optional wait-state FSM that stalls the pipeline per access.
module data_memory
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
)
(
    input  logic         clk_i,
    input  logic         rst_ni,
    data_memory_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam bit         HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [31:0]      wword;
    logic [31:0]      rdata;
    logic             err;
    logic             req;
    logic             stall;
    logic             we;

    mem_state_e state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Upper address bits are dropped, so accesses wrap around the array.
    assign idx   = bus.addr[IDX_W+1:2];
    assign rword = mem[idx];
    assign req   = bus.memread | bus.memwrite;

    dmem_align u_align (
        .memread  (bus.memread),
        .memwrite (bus.memwrite),
        .funct3   (bus.funct3),
        .addr_lo  (bus.addr[1:0]),
        .wdata    (bus.wdata),
        .rword    (rword),
        .rdata    (rdata),
        .wword    (wword),
        .err      (err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (HAS_WAIT && req && !err) begin
                    state_next = ST_WAIT;
                    cnt_next   = CNT_INIT;
                    stall      = 1'b1;
                end
            end
            ST_WAIT: begin
                // A dropped request is a flush: leave without completing it.
                if (req && cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                    stall    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign we = bus.memwrite & ~err & ~stall;

    always_ff @(posedge clk_i) begin
        if (we)
            mem[idx] <= wword;
    end

    assign bus.rdata = rdata;
    assign bus.stall = stall;
    assign bus.err   = err;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a zero-wait instance driven from a vector
// table and a three-wait-state instance exercised with hand-written sequences.
module tb_data_memory;
    import rv32i_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    data_memory_if bus0 ();
    data_memory_if bus1 ();

    data_memory #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus0)
    );

    data_memory #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut1 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bus1.memread  = rd;
        bus1.memwrite = wr;
        bus1.funct3   = f3;
        bus1.addr     = a;
        bus1.wdata    = wd;
    endtask

    // One full access on the wait-state instance: counts stall cycles, then checks data.
    task automatic access3(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input int exp_stalls, input logic [31:0] exp_rd);
        int n;
        n = 0;
        @(posedge clk_i); #1;
        drive1(rd, wr, f3, a, wd);
        @(negedge clk_i);
        while (bus1.stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
        chk({name, "_rdata"}, bus1.rdata, exp_rd);
        chk({name, "_err"}, 32'(bus1.err), 32'h0);
        $display("ws3 %s: addr=0x%08h stalls=%0d rdata=0x%08h", name, a, n, bus1.rdata);
    endtask

    initial begin
        rst_ni        = 1'b1;
        bus0.memread  = 1'b0;
        bus0.memwrite = 1'b0;
        bus0.funct3   = F3_W;
        bus0.addr     = 32'h0;
        bus0.wdata    = 32'h0;
        drive1(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        //            rd    wr    f3     addr        wdata         exp_rdata     err
        vecs[0]  = '{1'b0, 1'b1, F3_W,  32'h10,     32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, F3_W,  32'h10,     32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, F3_B,  32'h13,     32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, F3_BU, 32'h13,     32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, F3_H,  32'h10,     32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, F3_HU, 32'h12,     32'h0,        32'h0000DEAD, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, F3_B,  32'h11,     32'hAAAAAA55, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, F3_W,  32'h10,     32'h0,        32'hDEAD55EF, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, F3_H,  32'h11,     32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, F3_W,  32'h12,     32'h12345678, 32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, F3_W,  32'h10,     32'h0,        32'hDEAD55EF, 1'b0};
        vecs[11] = '{1'b0, 1'b1, F3_H,  32'h12,     32'hFFFFCAFE, 32'h00000000, 1'b0};
        vecs[12] = '{1'b1, 1'b0, F3_W,  32'h10,     32'h0,        32'hCAFE55EF, 1'b0};
        vecs[13] = '{1'b1, 1'b0, F3_W,  32'h1010,   32'h0,        32'hCAFE55EF, 1'b0};
        vecs[14] = '{1'b1, 1'b0, F3_B,  32'h11,     32'h0,        32'h00000055, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 3'b011, 32'h10,    32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b0, 1'b0, F3_W,  32'h10,     32'h0,        32'h00000000, 1'b0};
        vecs[17] = '{1'b0, 1'b1, F3_BU, 32'h10,     32'h000000FF, 32'h00000000, 1'b1};
        vecs[18] = '{1'b1, 1'b0, F3_HU, 32'h10,     32'h0,        32'h000055EF, 1'b0};

        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_stall0", 32'(bus0.stall), 32'h0);
        chk("reset_err0",   32'(bus0.err),   32'h0);
        chk("reset_rdata0", bus0.rdata,      32'h0);
        chk("reset_stall1", 32'(bus1.stall), 32'h0);
        chk("reset_rdata1", bus1.rdata,      32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk_i); #1;
            bus0.memread  = vecs[i].rd;
            bus0.memwrite = vecs[i].wr;
            bus0.funct3   = vecs[i].f3;
            bus0.addr     = vecs[i].addr;
            bus0.wdata    = vecs[i].wdata;
            @(negedge clk_i);
            chk($sformatf("v%0d_rdata", i), bus0.rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i),   32'(bus0.err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_stall", i), 32'(bus0.stall), 32'h0);
            $display("ws0 v%0d: rd=%0b wr=%0b f3=%03b addr=0x%08h rdata=0x%08h err=%0b",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, bus0.rdata, bus0.err);
        end
        @(posedge clk_i); #1;
        bus0.memread  = 1'b0;
        bus0.memwrite = 1'b0;

        access3("sw",  1'b0, 1'b1, F3_W, 32'h20, 32'h11223344, 3, 32'h0);
        access3("lw1", 1'b1, 1'b0, F3_W, 32'h20, 32'h0,        3, 32'h11223344);
        access3("lw2", 1'b1, 1'b0, F3_W, 32'h20, 32'h0,        3, 32'h11223344);

        @(posedge clk_i); #1;
        drive1(1'b1, 1'b0, F3_H, 32'h21, 32'h0);
        @(negedge clk_i);
        chk("ws3_lh_mis_err",   32'(bus1.err),   32'h1);
        chk("ws3_lh_mis_stall", 32'(bus1.stall), 32'h0);
        chk("ws3_lh_mis_rdata", bus1.rdata,      32'h0);
        $display("ws3 lh_mis: addr=0x00000021 err=%0b stall=%0b", bus1.err, bus1.stall);

        // Store aborted by reset during its second cycle.
        @(posedge clk_i); #1;
        drive1(1'b0, 1'b1, F3_W, 32'h20, 32'hAAAAAAAA);
        @(negedge clk_i);
        chk("ws3_rstabort_stall_c0", 32'(bus1.stall), 32'h1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        drive1(1'b0, 1'b0, F3_W, 32'h20, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ws3_rstabort_idle_stall", 32'(bus1.stall), 32'h0);
        $display("ws3 rstabort: store 0xaaaaaaaa @0x20 abandoned by reset");
        access3("lw_after_rst", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 3, 32'h11223344);

        // Store flushed by dropping memwrite during its second cycle.
        @(posedge clk_i); #1;
        drive1(1'b0, 1'b1, F3_W, 32'h20, 32'hBBBBBBBB);
        @(negedge clk_i);
        chk("ws3_flush_stall_c0", 32'(bus1.stall), 32'h1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("ws3_flush_stall_c1", 32'(bus1.stall), 32'h1);
        @(posedge clk_i); #1;
        drive1(1'b0, 1'b0, F3_W, 32'h20, 32'h0);
        @(negedge clk_i);
        chk("ws3_flush_stall_c2", 32'(bus1.stall), 32'h0);
        $display("ws3 flush: store 0xbbbbbbbb @0x20 abandoned by dropping memwrite");
        access3("lw_after_flush", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 3, 32'h11223344);

        @(posedge clk_i); #1;
        drive1(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
